edge_stream: RTL and testbench

Host-side terminal for one vertical edge of the core complex, implementing the opposite end of the node port handshake for each of `LANES` columns. Host values are queued and offered to the adjacent core row as a port writer would. Values the row writes are accepted as a port reader would and queued for the host. One instance sits on the top edge (lane buses to `up`/`outU`) and one on the bottom edge (`down`/`outD`).

---
 rtl/edge_stream.sv | 148 ++++++++++++++
 tb/tb_edge_stream.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_stream.sv
// -----------------------------------------------------------------------------
// edge_stream
//
// Host-side terminal for one vertical edge of the core complex. Each of the
// LANES columns gets two independent FIFOs:
//   inbound  : host -> complex. Presented to the adjacent core row the way a
//              port writer would present a value (rready/data, consumed by read).
//   outbound : complex -> host. Accepts values the row writes the way a port
//              reader would (write/wdata, acknowledged by a one-cycle wready).
//
// Ports (all lane buses are packed [LANES-1:0], data buses [LANES-1:0][WIDTH-1:0])
//   clk, rst        : sole clock, synchronous active-high reset
//   hostInValid/Data: host offers a value toward the complex
//   hostInReady     : inbound FIFO not full
//   rready / data   : inbound FIFO not empty / inbound head (to up/down)
//   read            : complex consumes the inbound head
//   write / wdata   : complex holds a value for the host
//   wready          : one-cycle acceptance pulse back to the writer
//   hostOutValid/Data: outbound FIFO not empty / outbound head
//   hostOutRead     : host pops the outbound head
//
// Every output is a function of registered state only; there is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
module edge_stream #(
    parameter int LANES = 4,
    parameter int WIDTH = 11,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LANES-1:0]             hostInValid,
    input  logic [LANES-1:0][WIDTH-1:0]  hostInData,
    output logic [LANES-1:0]             hostInReady,
    output logic [LANES-1:0]             rready,
    output logic [LANES-1:0][WIDTH-1:0]  data,
    input  logic [LANES-1:0]             read,
    input  logic [LANES-1:0]             write,
    input  logic [LANES-1:0][WIDTH-1:0]  wdata,
    output logic [LANES-1:0]             wready,
    output logic [LANES-1:0]             hostOutValid,
    output logic [LANES-1:0][WIDTH-1:0]  hostOutData,
    input  logic [LANES-1:0]             hostOutRead
);

    localparam int AW = $clog2(DEPTH);
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int PW = AW + 1;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane

            // ---------------- inbound FIFO (host -> complex) ----------------
            logic [WIDTH-1:0] in_mem_q [DEPTH];
            logic [PW-1:0]    in_wr_q, in_wr_d;
            logic [PW-1:0]    in_rd_q, in_rd_d;
            logic             in_full, in_empty;
            logic             in_push, in_pop;

            assign in_full  = (in_wr_q[AW] != in_rd_q[AW]) &&
                              (in_wr_q[AW-1:0] == in_rd_q[AW-1:0]);
            assign in_empty = (in_wr_q == in_rd_q);

            // Push qualification uses the pre-pop full flag: a pop on a full
            // FIFO frees a slot only from the next cycle on.
            assign in_push = hostInValid[gi] && !in_full;
            assign in_pop  = read[gi] && !in_empty;

            always_comb begin
                in_wr_d = in_wr_q;
                in_rd_d = in_rd_q;
                if (in_push) in_wr_d = in_wr_q + PW'(1);
                if (in_pop)  in_rd_d = in_rd_q + PW'(1);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    in_wr_q <= '0;
                    in_rd_q <= '0;
                    for (int j = 0; j < DEPTH; j++) begin
                        in_mem_q[j] <= '0;
                    end
                end else begin
                    in_wr_q <= in_wr_d;
                    in_rd_q <= in_rd_d;
                    if (in_push) begin
                        in_mem_q[in_wr_q[AW-1:0]] <= hostInData[gi];
                    end
                end
            end

            assign hostInReady[gi] = !in_full;
            assign rready[gi]      = !in_empty;
            assign data[gi]        = in_mem_q[in_rd_q[AW-1:0]];

            // ---------------- outbound FIFO (complex -> host) ---------------
            logic [WIDTH-1:0] out_mem_q [DEPTH];
            logic [PW-1:0]    out_wr_q, out_wr_d;
            logic [PW-1:0]    out_rd_q, out_rd_d;
            logic             out_full, out_empty;
            logic             out_cap, out_pop;
            logic             wready_q, wready_d;

            assign out_full  = (out_wr_q[AW] != out_rd_q[AW]) &&
                               (out_wr_q[AW-1:0] == out_rd_q[AW-1:0]);
            assign out_empty = (out_wr_q == out_rd_q);

            // The writer keeps write high during the acknowledge cycle; the
            // !wready_q term stops that stale request being captured twice.
            // Capture looks at the pre-pop full flag, so a host pop only lets
            // a blocked writer in on the following cycle.
            assign out_cap = write[gi] && !wready_q && !out_full;
            assign out_pop = hostOutRead[gi] && !out_empty;

            always_comb begin
                out_wr_d = out_wr_q;
                out_rd_d = out_rd_q;
                wready_d = out_cap;
                if (out_cap) out_wr_d = out_wr_q + PW'(1);
                if (out_pop) out_rd_d = out_rd_q + PW'(1);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_wr_q <= '0;
                    out_rd_q <= '0;
                    wready_q <= 1'b0;
                    for (int j = 0; j < DEPTH; j++) begin
                        out_mem_q[j] <= '0;
                    end
                end else begin
                    out_wr_q <= out_wr_d;
                    out_rd_q <= out_rd_d;
                    wready_q <= wready_d;
                    if (out_cap) begin
                        out_mem_q[out_wr_q[AW-1:0]] <= wdata[gi];
                    end
                end
            end

            assign wready[gi]       = wready_q;
            assign hostOutValid[gi] = !out_empty;
            assign hostOutData[gi]  = out_mem_q[out_rd_q[AW-1:0]];
        end
    endgenerate

endmodule

// File: tb/tb_edge_stream.sv
module tb_edge_stream;

    localparam int LANES = 4;
    localparam int WIDTH = 11;
    localparam int DEPTH = 4;

    logic                        clk = 1'b0;
    logic                        rst;
    logic [LANES-1:0]            hostInValid;
    logic [LANES-1:0][WIDTH-1:0] hostInData;
    logic [LANES-1:0]            hostInReady;
    logic [LANES-1:0]            rready;
    logic [LANES-1:0][WIDTH-1:0] data;
    logic [LANES-1:0]            read;
    logic [LANES-1:0]            write;
    logic [LANES-1:0][WIDTH-1:0] wdata;
    logic [LANES-1:0]            wready;
    logic [LANES-1:0]            hostOutValid;
    logic [LANES-1:0][WIDTH-1:0] hostOutData;
    logic [LANES-1:0]            hostOutRead;

    int checks = 0;
    int errors = 0;

    edge_stream #(.LANES(LANES), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .hostInValid(hostInValid), .hostInData(hostInData), .hostInReady(hostInReady),
        .rready(rready), .data(data), .read(read),
        .write(write), .wdata(wdata), .wready(wready),
        .hostOutValid(hostOutValid), .hostOutData(hostOutData), .hostOutRead(hostOutRead)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 time unit
    // after the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hostInValid = '0;
        hostInData  = '0;
        read        = '0;
        write       = '0;
        wdata       = '0;
        hostOutRead = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ($isunknown(data) || $isunknown(hostOutData)) begin
            errors++;
            $display("FAIL reset_xfree data=%h hostOutData=%h required no X", data, hostOutData);
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (rready !== 4'h0) begin
                errors++;
                $display("FAIL reset_rready cycle %0d got %h want 0", c, rready);
            end
            checks++;
            if (wready !== 4'h0) begin
                errors++;
                $display("FAIL reset_wready cycle %0d got %h want 0", c, wready);
            end
            checks++;
            if (hostInReady !== 4'hF) begin
                errors++;
                $display("FAIL reset_hostInReady cycle %0d got %h want f", c, hostInReady);
            end
            checks++;
            if (hostOutValid !== 4'h0) begin
                errors++;
                $display("FAIL reset_hostOutValid cycle %0d got %h want 0", c, hostOutValid);
            end
            tick();
        end
        $display("test_reset done");
    endtask

    task automatic test_reset_midflight();
        idle_inputs();
        hostInValid[0] = 1'b1; hostInData[0] = 11'd100; tick();
        hostInData[0] = 11'd101; tick();
        hostInValid[0] = 1'b0;
        write[0] = 1'b1; wdata[0] = 11'd200; tick();
        write[0] = 1'b0; tick();
        write[0] = 1'b1; wdata[0] = 11'd201; tick();
        write[0] = 1'b0; tick();
        checks++;
        if (rready[0] !== 1'b1 || hostOutValid[0] !== 1'b1 || hostOutData[0] !== 11'd200) begin
            errors++;
            $display("FAIL midflight_prefill rready0=%b hostOutValid0=%b hostOutData0=%0d want 1 1 200",
                     rready[0], hostOutValid[0], hostOutData[0]);
        end
        rst = 1'b1;
        write[0] = 1'b1; wdata[0] = 11'd300;
        tick();
        checks++;
        if (wready !== 4'h0) begin
            errors++;
            $display("FAIL midflight_wready got %h want 0", wready);
        end
        checks++;
        if (rready !== 4'h0 || hostOutValid !== 4'h0 || hostInReady !== 4'hF) begin
            errors++;
            $display("FAIL midflight_flush rready=%h hostOutValid=%h hostInReady=%h want 0 0 f",
                     rready, hostOutValid, hostInReady);
        end
        rst = 1'b0;
        write[0] = 1'b0;
        tick();
        checks++;
        if (wready !== 4'h0 || hostOutValid !== 4'h0) begin
            errors++;
            $display("FAIL midflight_nocapture wready=%h hostOutValid=%h want 0 0", wready, hostOutValid);
        end
        $display("test_reset_midflight done");
    endtask

    task automatic test_inbound_order();
        logic [WIDTH-1:0] exp_v [3];
        int k;
        exp_v[0] = 11'd5; exp_v[1] = 11'h7FD; exp_v[2] = 11'd999;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            hostInValid[2] = 1'b1;
            hostInData[2]  = exp_v[i];
            checks++;
            if (hostInReady[2] !== 1'b1) begin
                errors++;
                $display("FAIL order_ready push %0d got %b want 1", i, hostInReady[2]);
            end
            tick();
            if (i == 0) begin
                checks++;
                if (rready[2] !== 1'b1) begin
                    errors++;
                    $display("FAIL order_rready_latency got %b want 1", rready[2]);
                end
            end
        end
        hostInValid[2] = 1'b0;
        k = 0;
        for (int c = 0; c < 12 && k < 3; c++) begin
            read[2] = 1'b0;
            if (rready[2]) begin
                checks++;
                if (data[2] !== exp_v[k]) begin
                    errors++;
                    $display("FAIL order_data entry %0d got %h want %h", k, data[2], exp_v[k]);
                end
                read[2] = 1'b1;
                k++;
            end
            tick();
        end
        read[2] = 1'b0;
        checks++;
        if (k != 3) begin
            errors++;
            $display("FAIL order_count got %0d entries want 3", k);
        end
        checks++;
        if (rready !== 4'h0) begin
            errors++;
            $display("FAIL order_drained rready=%h want 0", rready);
        end
        $display("test_inbound_order done");
    endtask

    task automatic test_inbound_full();
        logic [WIDTH-1:0] exp_v [4];
        int k;
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            hostInValid[0] = 1'b1;
            hostInData[0]  = WIDTH'(10 + i);
            tick();
        end
        hostInValid[0] = 1'b0;
        checks++;
        if (hostInReady !== 4'hE || data[0] !== 11'd10) begin
            errors++;
            $display("FAIL full_reached hostInReady=%h data0=%0d want e 10", hostInReady, data[0]);
        end
        hostInValid[0] = 1'b1; hostInData[0] = 11'd14;
        tick();
        hostInValid[0] = 1'b0;
        checks++;
        if (hostInReady[0] !== 1'b0 || data[0] !== 11'd10) begin
            errors++;
            $display("FAIL full_ignore hostInReady0=%b data0=%0d want 0 10", hostInReady[0], data[0]);
        end
        // Pop + push on a full FIFO: only the pop happens.
        read[0] = 1'b1; hostInValid[0] = 1'b1; hostInData[0] = 11'd14;
        tick();
        checks++;
        if (hostInReady[0] !== 1'b1 || data[0] !== 11'd11) begin
            errors++;
            $display("FAIL full_poppush hostInReady0=%b data0=%0d want 1 11", hostInReady[0], data[0]);
        end
        // Pop + push with three entries: both happen, count stays three.
        hostInData[0] = 11'd15;
        tick();
        read[0] = 1'b0; hostInValid[0] = 1'b0;
        checks++;
        if (hostInReady[0] !== 1'b1 || data[0] !== 11'd12) begin
            errors++;
            $display("FAIL full_both hostInReady0=%b data0=%0d want 1 12", hostInReady[0], data[0]);
        end
        hostInValid[0] = 1'b1; hostInData[0] = 11'd16;
        tick();
        hostInValid[0] = 1'b0;
        checks++;
        if (hostInReady[0] !== 1'b0) begin
            errors++;
            $display("FAIL full_refill hostInReady0=%b want 0", hostInReady[0]);
        end
        exp_v[0] = 11'd12; exp_v[1] = 11'd13; exp_v[2] = 11'd15; exp_v[3] = 11'd16;
        k = 0;
        for (int c = 0; c < 12 && k < 4; c++) begin
            read[0] = 1'b0;
            if (rready[0]) begin
                checks++;
                if (data[0] !== exp_v[k]) begin
                    errors++;
                    $display("FAIL full_order entry %0d got %0d want %0d", k, data[0], exp_v[k]);
                end
                read[0] = 1'b1;
                k++;
            end
            tick();
        end
        read[0] = 1'b0;
        checks++;
        if (k != 4 || rready[0] !== 1'b0) begin
            errors++;
            $display("FAIL full_drain entries=%0d rready0=%b want 4 0", k, rready[0]);
        end
        $display("test_inbound_full done");
    endtask

    task automatic test_outbound_handshake();
        int pulses;
        idle_inputs();
        write[1] = 1'b1; wdata[1] = 11'd123;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (wready[1]) pulses++;
            if (c == 0) begin
                checks++;
                if (wready[1] !== 1'b1 || hostOutValid[1] !== 1'b1 || hostOutData[1] !== 11'd123) begin
                    errors++;
                    $display("FAIL hs_latency wready1=%b hostOutValid1=%b data1=%0d want 1 1 123",
                             wready[1], hostOutValid[1], hostOutData[1]);
                end
            end
            if (c == 1) write[1] = 1'b0;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL hs_pulses got %0d want 1", pulses);
        end
        hostOutRead[1] = 1'b1;
        tick();
        hostOutRead[1] = 1'b0;
        checks++;
        if (hostOutValid !== 4'h0) begin
            errors++;
            $display("FAIL hs_single_entry hostOutValid=%h want 0", hostOutValid);
        end
        $display("test_outbound_handshake done");
    endtask

    task automatic test_outbound_backpressure();
        logic [WIDTH-1:0] exp_v [4];
        int k;
        idle_inputs();
        for (int v = 1; v <= 4; v++) begin
            write[3] = 1'b1; wdata[3] = WIDTH'(v);
            tick();
            checks++;
            if (wready[3] !== 1'b1) begin
                errors++;
                $display("FAIL bp_fill value %0d wready3=%b want 1", v, wready[3]);
            end
            write[3] = 1'b0;
            tick();
        end
        write[3] = 1'b1; wdata[3] = 11'd77;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (wready[3] !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall cycle %0d wready3=%b want 0", c, wready[3]);
            end
        end
        checks++;
        if (hostOutData[3] !== 11'd1) begin
            errors++;
            $display("FAIL bp_head got %0d want 1", hostOutData[3]);
        end
        hostOutRead[3] = 1'b1;
        tick();
        hostOutRead[3] = 1'b0;
        checks++;
        if (wready[3] !== 1'b0 || hostOutData[3] !== 11'd2) begin
            errors++;
            $display("FAIL bp_popcycle wready3=%b head=%0d want 0 2", wready[3], hostOutData[3]);
        end
        tick();
        checks++;
        if (wready[3] !== 1'b1) begin
            errors++;
            $display("FAIL bp_release wready3=%b want 1", wready[3]);
        end
        write[3] = 1'b0;
        tick();
        checks++;
        if (wready[3] !== 1'b0) begin
            errors++;
            $display("FAIL bp_single_pulse wready3=%b want 0", wready[3]);
        end
        exp_v[0] = 11'd2; exp_v[1] = 11'd3; exp_v[2] = 11'd4; exp_v[3] = 11'd77;
        k = 0;
        for (int c = 0; c < 12 && k < 4; c++) begin
            hostOutRead[3] = 1'b0;
            if (hostOutValid[3]) begin
                checks++;
                if (hostOutData[3] !== exp_v[k]) begin
                    errors++;
                    $display("FAIL bp_order entry %0d got %0d want %0d", k, hostOutData[3], exp_v[k]);
                end
                hostOutRead[3] = 1'b1;
                k++;
            end
            tick();
        end
        hostOutRead[3] = 1'b0;
        checks++;
        if (k != 4 || hostOutValid[3] !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain entries=%0d hostOutValid3=%b want 4 0", k, hostOutValid[3]);
        end
        $display("test_outbound_backpressure done");
    endtask

    task automatic test_parallel();
        logic [WIDTH-1:0] in_exp  [LANES][16];
        logic [WIDTH-1:0] out_exp [LANES][16];
        int               in_head [LANES];
        int               in_tail [LANES];
        int               out_head[LANES];
        int               out_tail[LANES];
        logic             exp_wready[LANES];
        logic             prev_w  [LANES];
        logic             pend    [LANES];
        logic [WIDTH-1:0] wval    [LANES];
        int               ic;
        int               oc;
        logic             cap;
        logic             drain;
        for (int l = 0; l < LANES; l++) begin
            in_head[l] = 0; in_tail[l] = 0; out_head[l] = 0; out_tail[l] = 0;
            exp_wready[l] = 1'b0; prev_w[l] = 1'b0; pend[l] = 1'b0; wval[l] = '0;
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int cyc = 0; cyc < 440; cyc++) begin
            drain = (cyc >= 400);
            for (int l = 0; l < LANES; l++) begin
                ic = in_tail[l] - in_head[l];
                oc = out_tail[l] - out_head[l];
                checks++;
                if (hostInReady[l] !== (ic < DEPTH) || rready[l] !== (ic != 0)) begin
                    errors++;
                    $display("FAIL par_in_flags cyc %0d lane %0d ready=%b rready=%b model count %0d",
                             cyc, l, hostInReady[l], rready[l], ic);
                end
                if (ic != 0) begin
                    checks++;
                    if (data[l] !== in_exp[l][in_head[l] % 16]) begin
                        errors++;
                        $display("FAIL par_in_data cyc %0d lane %0d got %h want %h",
                                 cyc, l, data[l], in_exp[l][in_head[l] % 16]);
                    end
                end
                checks++;
                if (hostOutValid[l] !== (oc != 0) || wready[l] !== exp_wready[l]) begin
                    errors++;
                    $display("FAIL par_out_flags cyc %0d lane %0d valid=%b wready=%b want %b %b",
                             cyc, l, hostOutValid[l], wready[l], (oc != 0), exp_wready[l]);
                end
                if (oc != 0) begin
                    checks++;
                    if (hostOutData[l] !== out_exp[l][out_head[l] % 16]) begin
                        errors++;
                        $display("FAIL par_out_data cyc %0d lane %0d got %h want %h",
                                 cyc, l, hostOutData[l], out_exp[l][out_head[l] % 16]);
                    end
                end
                checks++;
                if (prev_w[l] && wready[l]) begin
                    errors++;
                    $display("FAIL par_wready_back_to_back cyc %0d lane %0d got 1 twice want single", cyc, l);
                end
                prev_w[l] = wready[l];

                // Writer: holds write through the acknowledge cycle, then drops it.
                if (exp_wready[l]) begin
                    write[l] = 1'b1;
                    pend[l]  = 1'b0;
                end else begin
                    if (!pend[l] && !drain && $urandom_range(0, 2) == 0) begin
                        pend[l] = 1'b1;
                        wval[l] = WIDTH'($urandom);
                    end
                    write[l] = pend[l];
                    wdata[l] = wval[l];
                end
                cap = write[l] && !exp_wready[l] && (oc < DEPTH);
                if (cap) begin
                    out_exp[l][out_tail[l] % 16] = wval[l];
                    out_tail[l]++;
                end
                exp_wready[l] = cap;

                hostInValid[l] = !drain && ($urandom_range(0, 1) == 1);
                hostInData[l]  = WIDTH'($urandom);
                if (hostInValid[l] && ic < DEPTH) begin
                    in_exp[l][in_tail[l] % 16] = hostInData[l];
                    in_tail[l]++;
                end
                read[l] = drain || ($urandom_range(0, 1) == 1);
                if (read[l] && ic != 0) in_head[l]++;
                hostOutRead[l] = drain || ($urandom_range(0, 1) == 1);
                if (hostOutRead[l] && oc != 0) out_head[l]++;
            end
            tick();
        end
        idle_inputs();
        for (int l = 0; l < LANES; l++) begin
            checks++;
            if (in_tail[l] != in_head[l] || out_tail[l] != out_head[l] || pend[l]) begin
                errors++;
                $display("FAIL par_model_drain lane %0d in %0d out %0d pend %b want 0 0 0",
                         l, in_tail[l] - in_head[l], out_tail[l] - out_head[l], pend[l]);
            end
        end
        checks++;
        if (rready !== 4'h0 || hostOutValid !== 4'h0) begin
            errors++;
            $display("FAIL par_dut_drain rready=%h hostOutValid=%h want 0 0", rready, hostOutValid);
        end
        $display("test_parallel done");
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_reset_midflight();
        test_inbound_order();
        test_inbound_full();
        test_outbound_handshake();
        test_outbound_backpressure();
        test_parallel();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
